// File: rtl/pll_pkg.sv
// Shared constants and helpers for the 50 MHz system PLL simulation model.
`timescale 1ns/10fs

package pll_pkg;

  // Nominal board reference and output frequencies, in MHz.
  localparam real CLKIN_FREQ_MHZ      = 27.0;
  localparam real CLKOUT0_FREQ_MHZ    = 50.0;

  // Lock qualification defaults.
  localparam int  LOCK_CYCLES_DEFAULT = 256;
  localparam real PERIOD_TOL_DEFAULT  = 0.01;

  // Clock period in ns for a frequency given in MHz.
  function automatic real period_ns(input real mhz);
    return 1000.0 / mhz;
  endfunction

endpackage

// File: rtl/pll_50_lock_det.sv
// Lock detector: measures each clkin1 period, counts consecutive in-tolerance
// periods, and drops lock on a bad period or when the reference disappears.
`timescale 1ns/10fs

module pll_50_lock_det
  import pll_pkg::*;
#(
  parameter real CLKIN_FREQ  = CLKIN_FREQ_MHZ,
  parameter int  LOCK_CYCLES = LOCK_CYCLES_DEFAULT,
  parameter real PERIOD_TOL  = PERIOD_TOL_DEFAULT
) (
  input  logic clkin1,
  input  logic rst_n,
  output logic lock
);

  localparam real TIN        = period_ns(CLKIN_FREQ);
  localparam real WD_TIMEOUT = 2.0 * TIN;
  // Width of the watchdog strobe; one time-precision step.
  localparam real WD_PULSE   = 0.00001;

  realtime last_edge;
  logic    have_edge;
  int      count;

  // Watchdog bookkeeping: time of the most recent clkin1 rise and the strobe
  // that tells the lock register the reference has gone quiet.
  realtime wd_stamp;
  logic    wd_fire;

  // True when a measured period lies within the relative tolerance of Tin.
  function automatic logic period_ok(input real period);
    real err;
    err = (period > TIN) ? (period - TIN) : (TIN - period);
    return (err <= PERIOD_TOL * TIN);
  endfunction

  // Arm a loss-of-clock timer on every clkin1 rise; a timer fires only if no
  // newer rise has moved wd_stamp in the meantime.
  always begin : watchdog
    wd_fire = 1'b0;
    @(posedge clkin1);
    wd_stamp = $realtime;
    fork
      begin
        #(WD_TIMEOUT);
        if (rst_n && (($realtime - wd_stamp) > TIN)) begin
          wd_fire = 1'b1;
          #(WD_PULSE);
          wd_fire = 1'b0;
        end
      end
    join_none
  end

  // Period measurement, stability counter and lock flag.
  always_ff @(posedge clkin1 or negedge rst_n or posedge wd_fire) begin
    if (!rst_n) begin
      lock      <= 1'b0;
      count     <= 0;
      last_edge <= 0.0;
      have_edge <= 1'b0;
    end else if (wd_fire) begin
      lock  <= 1'b0;
      count <= 0;
    end else begin
      // NOTE: non-blocking so every test below sees last_edge and count as
      // they stood before this edge, regardless of statement order.
      last_edge <= $realtime;
      have_edge <= 1'b1;
      if (have_edge) begin
        if (period_ok($realtime - last_edge)) begin
          if (count < LOCK_CYCLES) count <= count + 1;
          if (count + 1 >= LOCK_CYCLES) lock <= 1'b1;
        end else begin
          count <= 0;
          lock  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pll_50.sv
// 50 MHz system PLL simulation model: 27 MHz clkin1 in, clkout0 out once the
// reference has been stable long enough to raise lock.
`timescale 1ns/10fs

module pll_50
  import pll_pkg::*;
#(
  parameter real CLKIN_FREQ   = CLKIN_FREQ_MHZ,
  parameter real CLKOUT0_FREQ = CLKOUT0_FREQ_MHZ,
  parameter int  LOCK_CYCLES  = LOCK_CYCLES_DEFAULT,
  parameter real PERIOD_TOL   = PERIOD_TOL_DEFAULT
) (
  input  logic clkin1,
  input  logic rst_n,
  output logic clkout0,
  output logic lock
);

  localparam real HALF_NS = period_ns(CLKOUT0_FREQ) / 2.0;

  logic phase;

  pll_50_lock_det #(
    .CLKIN_FREQ  (CLKIN_FREQ),
    .LOCK_CYCLES (LOCK_CYCLES),
    .PERIOD_TOL  (PERIOD_TOL)
  ) u_lock_det (
    .clkin1 (clkin1),
    .rst_n  (rst_n),
    .lock   (lock)
  );

  // Free-running square wave, started in phase with the edge that sets lock
  // and allowed to run out its current period after lock falls.
  always begin : clkout_gen
    // NOTE: blocking assignments with delays are intended here; this is a
    // timed waveform generator, not clocked state.
    phase = 1'b0;
    @(posedge lock);
    while (lock) begin
      phase = 1'b1;
      #(HALF_NS);
      phase = 1'b0;
      #(HALF_NS);
    end
  end

  // Gating with lock forces clkout0 low the instant lock drops, so no runt
  // high pulse escapes while the generator finishes its half period.
  assign clkout0 = phase & lock;

endmodule

// File: tb/tb_pll_50.sv
// Directed bench for pll_50: lock latency, output waveform, reset, frequency
// step, clock loss and the period tolerance boundary.
`timescale 1ns/10fs

module tb_pll_50;

  localparam real TIN = 1000.0 / 27.0;

  typedef struct {
    string tag;
    int    expected;
  } exp_t;

  logic clkin1 = 1'b0;
  logic rst_n  = 1'b1;
  logic clkout0;
  logic lock;

  bit      clk_run   = 1'b0;
  real     clk_period = TIN;
  real     cur_period;
  realtime last_rise;

  int      falls = 0;
  realtime fall_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pll_50 dut (
    .clkin1  (clkin1),
    .rst_n   (rst_n),
    .clkout0 (clkout0),
    .lock    (lock)
  );

  // Reference clock; the period is latched at each rising edge.
  always begin
    if (clk_run) begin
      cur_period = clk_period;
      clkin1     = 1'b1;
      last_rise  = $realtime;
      #(cur_period / 2.0);
      clkin1     = 1'b0;
      #(cur_period / 2.0);
    end else begin
      #0.1;
    end
  end

  // Record every lock drop and when it happened.
  always @(negedge lock) begin
    falls  <= falls + 1;
    fall_t <= $realtime;
  end

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_real(input string tag, input real observed, input real expected,
                            input real tol);
    checks++;
    assert (((observed - expected) <= tol) && ((expected - observed) <= tol)) else begin
      errors++;
      $error("FAIL %s: observed %0.6f expected %0.6f +/- %0.6f", tag, observed, expected, tol);
    end
  endtask

  // Count clkin1 rises until lock is seen (-1 if never within max_edges) and
  // compare against the scoreboard entry pushed with the stimulus.
  task automatic await_lock(input int max_edges);
    exp_t e;
    int   seen = -1;
    int   bad  = 0;
    for (int k = 1; k <= max_edges && seen < 0; k++) begin
      @(posedge clkin1);
      #1;
      if (lock === 1'b1) seen = k;
      else if (clkout0 !== 1'b0) bad++;
    end
    e = sb.pop_front();
    check_int(e.tag, seen, e.expected);
    check_int({e.tag, "_clkout0_low_before_lock"}, bad, 0);
    if (seen > 0) check_bit({e.tag, "_clkout0_starts_high"}, clkout0, 1'b1);
  endtask

  initial begin
    int  base_falls;
    int  bad;
    real rise_prev, rise_now, fall_now, d, max_per, max_hi;

    // Reset state.
    #1 rst_n = 1'b0;
    clk_run = 1'b1;
    #1;
    check_bit("reset_lock", lock, 1'b0);
    check_bit("reset_clkout0", clkout0, 1'b0);

    // Power-up lock: release at ~101 ns, lock on rise 257.
    #99 rst_n = 1'b1;
    sb.push_back('{"powerup_lock_edge", 257});
    await_lock(400);
    base_falls = falls;
    #(50000.0 - $realtime);
    check_bit("lock_at_50us", lock, 1'b1);
    check_int("lock_falls_before_50us", falls - base_falls, 0);

    // Output waveform over 100 periods.
    max_per = 0.0;
    max_hi  = 0.0;
    @(posedge clkout0);
    rise_prev = $realtime;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkout0);
      fall_now = $realtime;
      @(posedge clkout0);
      rise_now = $realtime;
      d = rise_now - rise_prev - 20.0;
      if (d < 0.0) d = -d;
      if (d > max_per) max_per = d;
      d = fall_now - rise_prev - 10.0;
      if (d < 0.0) d = -d;
      if (d > max_hi) max_hi = d;
      rise_prev = rise_now;
    end
    check_real("clkout0_period_err", max_per, 0.0, 0.01);
    check_real("clkout0_high_err", max_hi, 0.0, 0.01);

    // Asynchronous reset between clkin1 edges.
    @(posedge clkin1);
    #5 rst_n = 1'b0;
    #0.001;
    check_bit("async_reset_lock", lock, 1'b0);
    check_bit("async_reset_clkout0", clkout0, 1'b0);
    #50 rst_n = 1'b1;
    sb.push_back('{"reset_relock_edge", 257});
    await_lock(400);

    // Frequency step to 25 MHz and back.
    @(posedge clkin1);
    #1 clk_period = 40.0;
    @(posedge clkin1);
    #1;
    check_bit("step_last_good_period_lock", lock, 1'b1);
    @(posedge clkin1);
    #1;
    check_bit("step_first_40ns_lock", lock, 1'b0);
    check_bit("step_first_40ns_clkout0", clkout0, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clkin1);
      #1;
      if (lock !== 1'b0 || clkout0 !== 1'b0) bad++;
    end
    check_int("step_held_unlocked", bad, 0);
    @(posedge clkin1);
    #1 clk_period = TIN;
    sb.push_back('{"step_relock_edge", 257});
    await_lock(400);

    // Loss of clock, then restart.
    @(posedge clkin1);
    #1 clk_run = 1'b0;
    base_falls = falls;
    #300;
    check_int("loss_lock_falls", falls - base_falls, 1);
    check_real("loss_detect_delay", fall_t - last_rise, 2.0 * TIN, 0.01);
    check_bit("loss_clkout0", clkout0, 1'b0);
    clk_run = 1'b1;
    sb.push_back('{"restart_relock_edge", 257});
    await_lock(400);

    // Tolerance boundary: +0.9 % locks, +2 % never does.
    @(posedge clkin1);
    #5 rst_n = 1'b0;
    clk_period = TIN * 1.009;
    #20 rst_n = 1'b1;
    sb.push_back('{"tol_0p9pct_lock_edge", 257});
    await_lock(400);
    @(posedge clkin1);
    #5 rst_n = 1'b0;
    clk_period = TIN * 1.02;
    #20 rst_n = 1'b1;
    sb.push_back('{"tol_2pct_never_locks", -1});
    await_lock(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit in case a DUT output never toggles.
  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no completion expected finish before 1 ms");
    $fatal(1, "time limit reached");
  end

endmodule
